pat_ctrl: RTL and testbench
===========================

PAT_CTRL -- requirements
Module: pat_ctrl

Interface
- REQ-001: Parameter CNT_W, default 8, sets the width of the match target and match counter.
- REQ-002: Parameter TO_W, default 16, sets the width of the timeout cycle budget.
- REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: cfg_valid  input  1  configuration offer.
- REQ-006: cfg_ready  output  1  high only in IDLE.
- REQ-007: cfg_seq  input  4  pattern to detect; first-received bit is MSB.
- REQ-008: cfg_target  input  CNT_W  number of matches that ends a run; 0 is legal.
- REQ-009: cfg_timeout  input  TO_W  RUN-cycle budget; 0 disables the timeout.
- REQ-010: start  input  1  single-cycle request to begin a run.
- REQ-011: abort  input  1  stops an active run.
- REQ-012: in_valid  input  1  qualifies in.
- REQ-013: in  input  1  serial data bit.
- REQ-014: busy  output  1  high in ARM and RUN.
- REQ-015: match  output  1  one-cycle pulse per detected match.
- REQ-016: match_cnt  output  CNT_W  matches counted in the current run.
- REQ-017: done  output  1  one-cycle pulse on entry to DONE.
- REQ-018: status  output  2  00 none, 01 target reached, 10 timeout, 11 aborted.

Function
- REQ-019: The FSM SHALL have the states IDLE, ARM, RUN and DONE.
- REQ-020: In IDLE, a cycle with cfg_valid high SHALL latch cfg_seq, cfg_target and cfg_timeout; the handshake completes when cfg_valid and cfg_ready are both high.
- REQ-021: When start is high in IDLE, the FSM SHALL move to ARM; start in any other state SHALL be ignored.
- REQ-022: When cfg_valid and start are high in the same IDLE cycle, the new configuration SHALL be the one used by the run.
- REQ-023: ARM SHALL last exactly one cycle: it clears the window, the fill count, match_cnt and the timeout counter, sets status to 00, then moves to RUN.
- REQ-024: In RUN, each cycle with in_valid high SHALL shift in into the window LSB; cycles with in_valid low SHALL leave the window unchanged.
- REQ-025: A match SHALL require at least 4 accepted bits since ARM and a shifted window equal to the latched pattern; matches may overlap.
- REQ-026: match SHALL pulse, and match_cnt SHALL increment, on the clock edge that accepts the completing bit.
- REQ-027: match_cnt SHALL saturate at its all-ones value.
- REQ-028: With a nonzero target, reaching match_cnt equal to the target SHALL move the FSM to DONE with status 01.
- REQ-029: With cfg_target 0, the run SHALL end only by timeout or abort.
- REQ-030: With a nonzero timeout, the timeout counter SHALL count RUN cycles whether or not in_valid is high.
- REQ-031: When the RUN-cycle count reaches the timeout value, the FSM SHALL move to DONE with status 10.
- REQ-032: An abort in ARM or RUN SHALL move the FSM to DONE with status 11.
- REQ-033: Exit priority SHALL be abort over target over timeout.
- REQ-034: A match that coincides with a timeout or abort SHALL still be counted.
- REQ-035: DONE SHALL last one cycle, with done high, then return to IDLE.
- REQ-036: status and match_cnt SHALL hold their values until the next ARM.

Reset
- REQ-037: Asserting reset (low) SHALL immediately force IDLE and clear all outputs, the window and all counters, including mid-run.
- REQ-038: Asserting reset SHALL restore the latched configuration to seq 0000, target 0 and timeout 0.
- REQ-039: After reset is released, cfg_ready SHALL be 1 and every other output SHALL be 0.

Structure
- REQ-040: A shared package SHALL hold the FSM state encoding and the status codes (ST_NONE, ST_HIT, ST_TIMEOUT, ST_ABORT).
- REQ-041: A single sub-module, pat_core, SHALL contain the 4-bit shift window, the fill counter and the compare, with ports clk, reset, clr, en, in, seq and hit.

Verification
- REQ-042: Reset behaviour: drop reset mid-RUN -> state IDLE, cfg_ready 1, match_cnt 0 and status 00 within the same cycle.
- REQ-043: Target stop: seq 0110, target 2, timeout 0, in stream 0,1,1,0,1,1,0,0,1,1,0 -> match on bit 3 and bit 6, done after bit 6, status 01, match_cnt 2.
- REQ-044: Free run: same stream with target 0, timeout 20, in_valid continuous -> 3 matches (bits 3, 6, 10), done after 20 RUN cycles, status 10, match_cnt 3.
- REQ-045: Gapped input: stream 0,1,1,0 with in_valid low for 2 cycles between every bit -> exactly one match; the window is unaffected by the gaps.
- REQ-046: Simultaneous exit: abort asserted in the cycle of the second match with target 2 -> status 11, match_cnt 2.
- REQ-047: Early match suppression: seq 0000 with input 0,0,0 after ARM -> no match; the fourth 0 -> match.

Source files
------------

// File: rtl/pat_ctrl_pkg.sv
// Shared definitions for the serial pattern-match controller:
// FSM state encoding, run status codes and window geometry.
package pat_ctrl_pkg;

  localparam int unsigned SeqW  = 4;
  localparam int unsigned FillW = $clog2(SeqW + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HIT     = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ABORT   = 2'b11
  } status_e;

endpackage

// File: rtl/pat_core.sv
// Serial 4-bit sliding window with fill tracking; flags a hit when the bit being
// accepted completes a window that equals the configured pattern.
module pat_core
  import pat_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            in,
  input  logic [SeqW-1:0] seq,
  output logic            hit
);

  logic [SeqW-1:0]  win_q, win_d;
  logic [SeqW-1:0]  shifted;
  logic [FillW-1:0] fill_q, fill_d;

  assign shifted = {win_q[SeqW-2:0], in};

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (en) begin
      win_d = shifted;
      if (fill_q != FillW'(SeqW)) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // The accepted bit is the SeqW-th one once SeqW-1 bits are already held.
  assign hit = en && !clr && (fill_q >= FillW'(SeqW - 1)) && (shifted == seq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pat_ctrl.sv
// Run controller: latches a pattern configuration, arms the window, counts matches
// in RUN and ends the run on target, timeout or abort with a status code.
module pat_ctrl
  import pat_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SeqW-1:0]  cfg_seq,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic [1:0]       status
);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [SeqW-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             match_q, match_d;
  logic             done_q, done_d;

  logic             core_clr;
  logic             core_en;
  logic             core_hit;
  logic [CNT_W-1:0] cnt_inc;

  pat_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr),
    .en    (core_en),
    .in    (in),
    .seq   (seq_q),
    .hit   (core_hit)
  );

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    seq_d     = seq_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    match_d   = 1'b0;
    done_d    = 1'b0;
    core_clr  = 1'b0;
    core_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          seq_d     = cfg_seq;
          target_d  = cfg_target;
          timeout_d = cfg_timeout;
        end
        if (start) begin
          state_d = StArm;
        end
      end

      StArm: begin
        core_clr = 1'b1;
        cnt_d    = '0;
        to_d     = '0;
        status_d = ST_NONE;
        if (abort) begin
          state_d  = StDone;
          status_d = ST_ABORT;
          done_d   = 1'b1;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        core_en = in_valid;
        to_d    = to_q + 1'b1;
        if (core_hit) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc;
        end
        // A match on the exiting edge is still counted, whatever the exit cause.
        if (abort) begin
          state_d  = StDone;
          status_d = ST_ABORT;
          done_d   = 1'b1;
        end else if (core_hit && (target_q != '0) && (cnt_d == target_q)) begin
          state_d  = StDone;
          status_d = ST_HIT;
          done_d   = 1'b1;
        end else if ((timeout_q != '0) && (to_d == timeout_q)) begin
          state_d  = StDone;
          status_d = ST_TIMEOUT;
          done_d   = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      status_q  <= ST_NONE;
      seq_q     <= '0;
      target_q  <= '0;
      timeout_q <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      seq_q     <= seq_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      match_q   <= match_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q == StArm) || (state_q == StRun);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule

// File: tb/tb_pat_ctrl.sv
// Scoreboard bench for pat_ctrl: stimulus queues expected match/done events with
// their due cycle; a negedge monitor pops and checks them as the DUT pulses.
module tb_pat_ctrl;
  import pat_ctrl_pkg::*;

  localparam int CNT_W = 8;
  localparam int TO_W  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [3:0]       cfg_seq = '0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in = 1'b0;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic [1:0]       status;

  pat_ctrl #(
    .CNT_W (CNT_W),
    .TO_W  (TO_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_seq     (cfg_seq),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (in),
    .busy        (busy),
    .match       (match),
    .match_cnt   (match_cnt),
    .done        (done),
    .status      (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int due;
    int cnt;
    int st;
  } exp_t;

  exp_t exp_match[$];
  exp_t exp_done[$];

  // Stream 0,1,1,0,1,1,0,0,1,1,0 with element i at bit i.
  logic [10:0] sbits = 11'b01100110110;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (match) begin
        if (exp_match.size() == 0) begin
          chk("match_unexpected", cyc, -1);
        end else begin
          e = exp_match.pop_front();
          chk("match_cycle", cyc, e.due);
          chk("match_cnt", int'(match_cnt), e.cnt);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", cyc, -1);
        end else begin
          e = exp_done.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("done_status", int'(status), e.st);
          chk("done_cnt", int'(match_cnt), e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] s, input int tgt, input int to);
    cfg_valid   = 1'b1;
    cfg_seq     = s;
    cfg_target  = CNT_W'(tgt);
    cfg_timeout = TO_W'(to);
    tick();
    cfg_valid = 1'b0;
  endtask

  // Leaves the bench at the first RUN cycle; s is the cycle start was driven in.
  task automatic start_run(output int s);
    s     = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send(input logic b, input bit m, input int c);
    in_valid = 1'b1;
    in       = b;
    if (m) exp_match.push_back('{due: cyc + 1, cnt: c, st: 0});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_done(input int due, input status_e st, input int c);
    exp_done.push_back('{due: due, cnt: c, st: int'(st)});
  endtask

  task automatic do_abort(input int c);
    abort = 1'b1;
    push_done(cyc + 1, ST_ABORT, c);
    tick();
    abort = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    chk("rst_status", int'(status), 0);
    tick();

    // Target stop: matches at bits 3 and 6, run ends on bit 6; later bits ignored.
    set_cfg(4'b0110, 2, 0);
    start_run(s);
    chk("busy_run", int'(busy), 1);
    chk("cfg_ready_run", int'(cfg_ready), 0);
    for (int i = 0; i < 11; i++) begin
      if (i == 6) push_done(cyc + 1, ST_HIT, 2);
      send(sbits[i], (i == 3 || i == 6), (i == 3) ? 1 : 2);
    end
    chk("hold_status_hit", int'(status), int'(ST_HIT));
    chk("hold_cnt_hit", int'(match_cnt), 2);
    chk("idle_ready", int'(cfg_ready), 1);

    // Free run with timeout 20: matches at bits 3, 6, 10.
    set_cfg(4'b0110, 0, 20);
    start_run(s);
    push_done(s + 22, ST_TIMEOUT, 3);
    for (int i = 0; i < 20; i++) begin
      send((i < 11) ? sbits[i] : 1'b0, (i == 3 || i == 6 || i == 10),
           (i == 3) ? 1 : ((i == 6) ? 2 : 3));
    end
    tick();
    chk("hold_status_to", int'(status), int'(ST_TIMEOUT));
    chk("hold_cnt_to", int'(match_cnt), 3);

    // Gapped input: two invalid cycles after each bit; exactly one match.
    set_cfg(4'b0110, 0, 0);
    start_run(s);
    for (int i = 0; i < 4; i++) begin
      send(sbits[i], (i == 3), 1);
      in = ~in;
      tick();
      tick();
    end
    do_abort(1);

    // Abort coincides with the second (target) match: abort wins, match counted.
    set_cfg(4'b0110, 2, 0);
    start_run(s);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        abort = 1'b1;
        push_done(cyc + 1, ST_ABORT, 2);
      end
      send(sbits[i], (i == 3 || i == 6), (i == 3) ? 1 : 2);
      abort = 1'b0;
    end
    tick();

    // Config offered with start in the same cycle wins; seq 0000 needs 4 bits.
    set_cfg(4'b0110, 5, 0);
    cfg_valid   = 1'b1;
    cfg_seq     = 4'b0000;
    cfg_target  = '0;
    cfg_timeout = '0;
    start       = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, (i >= 3), i - 2);
    end
    do_abort(2);

    // Abort during ARM: status aborted and the previous count is cleared.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_abort(0);

    // Reset mid-RUN clears immediately and restores the zero configuration.
    set_cfg(4'b0110, 0, 0);
    start_run(s);
    for (int i = 0; i < 5; i++) send(sbits[i], (i == 3), 1);
    chk("busy_before_rst", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_cfg_ready", int'(cfg_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_match_cnt", int'(match_cnt), 0);
    chk("midrst_status", int'(status), 0);
    tick();
    reset = 1'b1;
    tick();
    start_run(s);
    for (int i = 0; i < 4; i++) send(1'b0, (i == 3), 1);
    do_abort(1);

    repeat (3) tick();
    chk("match_queue_empty", exp_match.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
